jt51_wrqueue: RTL and testbench

//  Host-side register write queue that feeds jt51_mmr. Buffers CPU (address, data)

---
 rtl/jt51_wrqueue.sv | 180 ++++++++++++++++++
 tb/tb_jt51_wrqueue.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt51_wrqueue.sv
// Host-side write queue for jt51_mmr: buffers (address, data) pairs and replays
// each as an a0=0 / a0=1 write pair, waiting for mmr_busy to clear after data.
module jt51_wrqueue #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    push_addr,
  input  logic [7:0]    push_data,
  input  logic          flush,
  input  logic          ovf_clr,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          ovf,
  output logic          q_busy,
  output logic          mmr_write,
  output logic          mmr_a0,
  output logic [7:0]    mmr_din,
  input  logic          mmr_busy
);

  localparam int          DEPTH     = 2**AW;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_GAP,
    S_DATA,
    S_WAIT1,
    S_WAITB
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [15:0]   r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          r_ovf;

  logic [7:0]    r_h_addr;
  logic [7:0]    r_h_data;
  logic [7:0]    r_last_addr;
  logic          r_last_valid;

  logic          r_mmr_write;
  logic          r_mmr_a0;
  logic [7:0]    r_mmr_din;

  logic [AW:0]   w_level;
  logic          w_full;
  logic          w_empty;
  logic          w_push_ok;
  logic          w_pop;
  logic [15:0]   w_head;

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping. Pointers carry one extra bit so full and empty differ.
  // ---------------------------------------------------------------------------
  assign w_level   = r_wr_ptr - r_rd_ptr;
  assign w_full    = (w_level == DEPTH_CNT);
  assign w_empty   = (w_level == '0);
  // Full is judged before any same-cycle pop; flush swallows a concurrent push.
  assign w_push_ok = push && !w_full && !flush;
  assign w_pop     = (r_state == S_IDLE) && !w_empty && !flush;
  assign w_head    = r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: the storage array has no reset; pointers alone define what is valid,
  // so clearing the entries would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push_ok)
      r_mem[r_wr_ptr[AW-1:0]] <= {push_addr, push_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (flush)
        r_rd_ptr <= r_wr_ptr;
      else if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ovf <= 1'b0;
    else if (ovf_clr)
      r_ovf <= 1'b0;
    else if (push && w_full)
      r_ovf <= 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Playout FSM: state register plus combinational next-state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // NOTE: w_state_nxt is given a default before the case so that no path through
  // this block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          if (r_last_valid && (w_head[15:8] == r_last_addr))
            w_state_nxt = S_DATA;
          else
            w_state_nxt = S_ADDR;
        end
      end
      S_ADDR:  w_state_nxt = S_GAP;
      S_GAP:   w_state_nxt = S_DATA;
      S_DATA:  w_state_nxt = S_WAIT1;
      // jt51_mmr raises busy a cycle after the data write, so do not look yet.
      S_WAIT1: w_state_nxt = S_WAITB;
      S_WAITB: begin
        if (!mmr_busy)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Head entry capture and registered bus outputs driven from the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_addr     <= '0;
      r_h_data     <= '0;
      r_last_addr  <= '0;
      r_last_valid <= 1'b0;
      r_mmr_write  <= 1'b0;
      r_mmr_a0     <= 1'b0;
      r_mmr_din    <= '0;
    end else begin
      r_mmr_write <= 1'b0;
      if (w_pop) begin
        r_h_addr <= w_head[15:8];
        r_h_data <= w_head[7:0];
      end
      case (r_state)
        S_ADDR: begin
          r_mmr_write  <= 1'b1;
          r_mmr_a0     <= 1'b0;
          r_mmr_din    <= r_h_addr;
          r_last_addr  <= r_h_addr;
          r_last_valid <= 1'b1;
        end
        S_DATA: begin
          r_mmr_write <= 1'b1;
          r_mmr_a0    <= 1'b1;
          r_mmr_din   <= r_h_data;
        end
        default: ;
      endcase
    end
  end

  assign full      = w_full;
  assign empty     = w_empty;
  assign level     = w_level;
  assign ovf       = r_ovf;
  assign q_busy    = !w_empty || (r_state != S_IDLE);
  assign mmr_write = r_mmr_write;
  assign mmr_a0    = r_mmr_a0;
  assign mmr_din   = r_mmr_din;

endmodule

// File: tb/tb_jt51_wrqueue.sv
// Bench for jt51_wrqueue: cycle table for latency/skip path, directed overflow,
// flush and reset sequences, then random batches against a pair-stream model.
module tb_jt51_wrqueue;

  localparam int AW    = 3;
  localparam int DEPTH = 2**AW;

  logic          clk;
  logic          rst_n;
  logic          push;
  logic [7:0]    push_addr;
  logic [7:0]    push_data;
  logic          flush;
  logic          ovf_clr;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          ovf;
  logic          q_busy;
  logic          mmr_write;
  logic          mmr_a0;
  logic [7:0]    mmr_din;
  logic          mmr_busy;

  logic          use_model;
  logic          tb_busy;
  int            busy_len;
  int            busy_cnt;
  logic [7:0]    cur_addr;
  logic [7:0]    addr_log[$];
  logic [15:0]   data_log[$];

  int            total;
  int            bad;

  typedef struct packed {
    logic        p;
    logic [7:0]  a;
    logic [7:0]  d;
    logic        b;
    logic        e_w;
    logic        e_a0;
    logic [7:0]  e_din;
    logic [AW:0] e_lvl;
    logic        e_qb;
  } vec_t;

  vec_t          tv[21];
  logic [15:0]   exp_data[$];
  logic [7:0]    exp_addr[$];
  logic          m_lv;
  logic [7:0]    m_last;
  int            base_d;
  int            base_a;
  logic          found;

  jt51_wrqueue #(.AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_addr (push_addr),
    .push_data (push_data),
    .flush     (flush),
    .ovf_clr   (ovf_clr),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .ovf       (ovf),
    .q_busy    (q_busy),
    .mmr_write (mmr_write),
    .mmr_a0    (mmr_a0),
    .mmr_din   (mmr_din),
    .mmr_busy  (mmr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mmr_busy = use_model ? (busy_cnt != 0) : tb_busy;

  // jt51_mmr/jt51_reg stand-in: busy rises the cycle after a data write is seen
  // and every completed (address, data) pair is logged as the register file sees it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= 0;
    end else begin
      if (mmr_write && mmr_a0)
        busy_cnt <= busy_len;
      else if (busy_cnt != 0)
        busy_cnt <= busy_cnt - 1;
      if (mmr_write) begin
        if (!mmr_a0) begin
          addr_log.push_back(mmr_din);
          cur_addr <= mmr_din;
        end else begin
          data_log.push_back({cur_addr, mmr_din});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [7:0] a, input logic [7:0] d);
    push      = 1'b1;
    push_addr = a;
    push_data = d;
    tick();
    push      = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_log(input string name, input int n);
    int c;
    c = 0;
    while (data_log.size() < n && c < 600) begin
      tick();
      c++;
    end
    check(name, 32'(data_log.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while (q_busy && c < 600) begin
      tick();
      c++;
    end
    check(name, {31'd0, q_busy}, 32'd0);
  endtask

  function automatic vec_t mk(input logic p, input logic [7:0] a, input logic [7:0] d,
                              input logic b, input logic w, input logic a0,
                              input logic [7:0] din, input logic [AW:0] lvl, input logic qb);
    mk = '{p, a, d, b, w, a0, din, lvl, qb};
  endfunction

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; push = 1'b0; push_addr = '0; push_data = '0;
    flush = 1'b0; ovf_clr = 1'b0; use_model = 1'b0; tb_busy = 1'b0; busy_len = 2;

    // push, addr, data, busy | write, a0, din, level, q_busy
    tv[0]  = mk(1, 8'h20, 8'hC7, 0,  0, 0, 8'h00, 1, 1);
    tv[1]  = mk(0, 8'h00, 8'h00, 0,  0, 0, 8'h00, 0, 1);
    tv[2]  = mk(0, 8'h00, 8'h00, 0,  1, 0, 8'h20, 0, 1);
    tv[3]  = mk(0, 8'h00, 8'h00, 0,  0, 0, 8'h20, 0, 1);
    tv[4]  = mk(0, 8'h00, 8'h00, 0,  1, 1, 8'hC7, 0, 1);
    tv[5]  = mk(0, 8'h00, 8'h00, 0,  0, 1, 8'hC7, 0, 1);
    tv[6]  = mk(0, 8'h00, 8'h00, 1,  0, 1, 8'hC7, 0, 1);
    tv[7]  = mk(0, 8'h00, 8'h00, 1,  0, 1, 8'hC7, 0, 1);
    tv[8]  = mk(0, 8'h00, 8'h00, 0,  0, 1, 8'hC7, 0, 0);
    tv[9]  = mk(1, 8'h28, 8'h4A, 0,  0, 1, 8'hC7, 1, 1);
    tv[10] = mk(0, 8'h00, 8'h00, 0,  0, 1, 8'hC7, 0, 1);
    tv[11] = mk(0, 8'h00, 8'h00, 0,  1, 0, 8'h28, 0, 1);
    tv[12] = mk(0, 8'h00, 8'h00, 0,  0, 0, 8'h28, 0, 1);
    tv[13] = mk(1, 8'h28, 8'h50, 0,  1, 1, 8'h4A, 1, 1);
    tv[14] = mk(0, 8'h00, 8'h00, 1,  0, 1, 8'h4A, 1, 1);
    tv[15] = mk(0, 8'h00, 8'h00, 1,  0, 1, 8'h4A, 1, 1);
    tv[16] = mk(0, 8'h00, 8'h00, 0,  0, 1, 8'h4A, 1, 1);
    tv[17] = mk(0, 8'h00, 8'h00, 0,  0, 1, 8'h4A, 0, 1);
    tv[18] = mk(0, 8'h00, 8'h00, 0,  1, 1, 8'h50, 0, 1);
    tv[19] = mk(0, 8'h00, 8'h00, 0,  0, 1, 8'h50, 0, 1);
    tv[20] = mk(0, 8'h00, 8'h00, 0,  0, 1, 8'h50, 0, 0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_level", 32'(level), 32'd0);
    check("rst_flags", {28'd0, full, empty, ovf, q_busy}, 32'b0100);
    check("rst_bus",   {22'd0, mmr_write, mmr_a0, mmr_din}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Latency and skip-address path, cycle by cycle.
    for (int i = 0; i < 21; i++) begin
      push = tv[i].p; push_addr = tv[i].a; push_data = tv[i].d; tb_busy = tv[i].b;
      tick();
      check($sformatf("vec%0d", i), {17'd0, mmr_write, mmr_a0, mmr_din, level, q_busy},
            {17'd0, tv[i].e_w, tv[i].e_a0, tv[i].e_din, tv[i].e_lvl, tv[i].e_qb});
    end
    push = 1'b0; tb_busy = 1'b0;

    // Overflow with busy held high.
    base_d = data_log.size();
    base_a = addr_log.size();
    tb_busy = 1'b1;
    do_push(8'h30, 8'h11);
    repeat (8) tick();
    for (int i = 0; i <= DEPTH; i++) do_push(8'(8'h40 + i), 8'(i));
    check("ovf_full",  {29'd0, full, empty, ovf}, 32'b101);
    check("ovf_level", 32'(level), 32'(DEPTH));
    repeat (2) tick();
    check("ovf_sticky", {31'd0, ovf}, 32'd1);
    ovf_clr = 1'b1;
    do_push(8'h77, 8'h77);
    ovf_clr = 1'b0;
    check("ovf_clr_prio", {31'd0, ovf}, 32'd0);
    do_push(8'h78, 8'h78);
    check("ovf_reset", {31'd0, ovf}, 32'd1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("ovf_cleared", {31'd0, ovf}, 32'd0);
    tb_busy = 1'b0;
    tick();
    check("pre_pop_level", 32'(level), 32'(DEPTH));
    do_push(8'h79, 8'h79);
    check("pop_push_full", {27'd0, ovf, level}, {27'd0, 1'b1, 4'(DEPTH - 1)});
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    busy_len = 2; use_model = 1'b1;
    wait_log("ovf_drain", base_d + DEPTH + 1);
    wait_idle("ovf_idle");
    repeat (20) tick();
    check("ovf_count", 32'(data_log.size() - base_d), 32'(DEPTH + 1));
    check("ovf_first", 32'(data_log[base_d]), 32'h3011);
    for (int i = 0; i < DEPTH; i++)
      check($sformatf("ovf_ent%0d", i), 32'(data_log[base_d + 1 + i]), {16'd0, 8'(8'h40 + i), 8'(i)});
    check("ovf_addr_cnt", 32'(addr_log.size() - base_a), 32'(DEPTH + 1));

    // Flush while waiting on busy.
    busy_len = 6;
    base_d = data_log.size();
    do_push(8'h50, 8'h01);
    do_push(8'h51, 8'h02);
    do_push(8'h52, 8'h03);
    wait_log("fl_first", base_d + 1);
    repeat (2) tick();
    flush = 1'b1; tick(); flush = 1'b0;
    check("fl_level", {27'd0, empty, level}, {27'd0, 1'b1, 4'd0});
    wait_idle("fl_idle");
    repeat (20) tick();
    check("fl_count", 32'(data_log.size() - base_d), 32'd1);
    check("fl_entry", 32'(data_log[base_d]), 32'h5001);

    // Reset during the data pulse, then the address phase must reappear.
    busy_len = 2;
    do_push(8'h60, 8'h01);
    wait_idle("rs_idle0");
    do_push(8'h60, 8'h02);
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (mmr_write && mmr_a0) found = 1'b1;
    end
    check("rs_pulse", {23'd0, found, mmr_din}, {23'd0, 1'b1, 8'h02});
    rst_n = 1'b0;
    #1;
    check("rs_async", {29'd0, mmr_write, q_busy, empty}, 32'b001);
    base_d = data_log.size();
    base_a = addr_log.size();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_push(8'h60, 8'h03);
    wait_log("rs_data", base_d + 1);
    check("rs_entry", 32'(data_log[base_d]), 32'h6003);
    check("rs_addr_cnt", 32'(addr_log.size() - base_a), 32'd1);
    check("rs_addr", 32'(addr_log[base_a]), 32'h60);
    wait_idle("rs_idle1");

    // Random batches; the model is just the ordered pair stream plus the
    // rule that an address write is emitted when it differs from the previous one.
    do_reset();
    m_lv = 1'b0; m_last = '0;
    exp_data.delete(); exp_addr.delete();
    base_d = data_log.size();
    base_a = addr_log.size();
    busy_len = 12;
    exp_data.push_back(16'h0811);
    exp_addr.push_back(8'h08);
    m_lv = 1'b1; m_last = 8'h08;
    do_push(8'h08, 8'h11);
    wait_log("rnd_seed", base_d + 1);
    for (int b = 0; b < 24; b++) begin
      int k;
      wait_log($sformatf("rnd_wait%0d", b), base_d + exp_data.size());
      k = (b < 2) ? DEPTH : int'($urandom_range(1, DEPTH));
      if (b >= 2) busy_len = int'($urandom_range(0, 4));
      for (int j = 0; j < k; j++) begin
        logic [7:0] a;
        logic [7:0] d;
        case ($urandom_range(0, 3))
          0:       a = 8'h20;
          1:       a = 8'h28;
          2:       a = 8'h08;
          default: a = 8'($urandom);
        endcase
        d = 8'($urandom);
        exp_data.push_back({a, d});
        if (!m_lv || a != m_last) exp_addr.push_back(a);
        m_lv = 1'b1; m_last = a;
        do_push(a, d);
        if (b >= 2) repeat ($urandom_range(0, 2)) tick();
      end
      if (b < 2)
        check($sformatf("rnd_full%0d", b), {27'd0, full, level}, {27'd0, 1'b1, 4'(DEPTH)});
      check($sformatf("rnd_ovf%0d", b), {31'd0, ovf}, 32'd0);
    end
    wait_log("rnd_drain", base_d + exp_data.size());
    wait_idle("rnd_idle");
    repeat (10) tick();
    check("rnd_data_cnt", 32'(data_log.size() - base_d), 32'(exp_data.size()));
    check("rnd_addr_cnt", 32'(addr_log.size() - base_a), 32'(exp_addr.size()));
    for (int i = 0; i < exp_data.size(); i++)
      if (base_d + i < data_log.size())
        check($sformatf("rnd_data%0d", i), 32'(data_log[base_d + i]), 32'(exp_data[i]));
    for (int i = 0; i < exp_addr.size(); i++)
      if (base_a + i < addr_log.size())
        check($sformatf("rnd_addr%0d", i), 32'(addr_log[base_a + i]), 32'(exp_addr[i]));
    check("end_level", {27'd0, empty, level}, {27'd0, 1'b1, 4'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
